// File: rtl/pcie_msg_queue_mgr.sv
// Per-queue circular SRAM space allocator for assembled PCIe messages, with
// firmware read-pointer tracking and count/timeout interrupt coalescing.
module pcie_msg_queue_mgr #(
   parameter int NUM_Q  = 15,
   parameter int QID_W  = 4,
   parameter int ADDR_W = 10,
   parameter int PTR_W  = 8,
   parameter int CNT_W  = 4,
   parameter int TMR_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_Q-1:0]         i_q_enable,
   input  logic [NUM_Q*ADDR_W-1:0]  i_q_init_addr,
   input  logic [NUM_Q*PTR_W-1:0]   i_q_depth,
   input  logic                     i_alloc_req,
   input  logic [QID_W-1:0]         i_alloc_qid,
   input  logic [PTR_W-1:0]         i_alloc_len,
   output logic                     o_alloc_done,
   output logic                     o_alloc_err,
   output logic [ADDR_W-1:0]        o_alloc_addr,
   input  logic                     i_rptr_we,
   input  logic [QID_W-1:0]         i_rptr_qid,
   input  logic [PTR_W-1:0]         i_rptr_data,
   output logic [NUM_Q*PTR_W-1:0]   o_q_wptr,
   output logic [NUM_Q*(PTR_W+1)-1:0] o_q_used,
   output logic [NUM_Q-1:0]         o_q_empty,
   input  logic [CNT_W-1:0]         i_coal_cnt,
   input  logic [TMR_W-1:0]         i_coal_tmo,
   input  logic [NUM_Q-1:0]         i_intr_mask,
   input  logic [NUM_Q-1:0]         i_intr_clear,
   output logic [NUM_Q-1:0]         o_intr_status,
   output logic                     o_msg_interrupt,
   output logic [15:0]              o_drop_cnt
);
   localparam int UW = PTR_W + 1;

   logic [PTR_W-1:0]  r_wptr [NUM_Q];
   logic [PTR_W-1:0]  r_rptr [NUM_Q];
   logic [UW-1:0]     r_used [NUM_Q];
   logic [CNT_W-1:0]  r_pend [NUM_Q];
   logic [TMR_W-1:0]  r_tmr  [NUM_Q];
   logic [NUM_Q-1:0]  r_status, r_en_d;
   logic              r_irq, r_done, r_err;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_drop;

   logic              w_a_qok, w_a_en, w_a_ok;
   logic [UW-1:0]     w_a_depth, w_a_used, w_a_free, w_a_sum;
   logic [PTR_W-1:0]  w_a_wptr, w_a_wnext;
   logic [ADDR_W-1:0] w_a_init, w_a_addr;
   logic              w_r_qok, w_r_ok;
   logic [UW-1:0]     w_r_depth, w_r_used, w_r_diff, w_r_cons;
   logic [PTR_W-1:0]  w_r_rptr;
   logic [CNT_W-1:0]  w_thr;
   logic [NUM_Q-1:0]  w_fall, w_hit_a, w_hit_r, w_set;

   // Allocation: select the addressed queue's state, then judge room against pre-update occupancy.
   always_comb begin
      w_a_qok   = 1'b0;
      w_a_en    = 1'b0;
      w_a_depth = '0;
      w_a_used  = '0;
      w_a_wptr  = '0;
      w_a_init  = '0;
      for (int q = 0; q < NUM_Q; q++) begin
         if (i_alloc_qid == QID_W'(q)) begin
            w_a_qok   = 1'b1;
            w_a_en    = i_q_enable[q];
            w_a_depth = UW'(i_q_depth[q*PTR_W +: PTR_W]);
            w_a_used  = r_used[q];
            w_a_wptr  = r_wptr[q];
            w_a_init  = i_q_init_addr[q*ADDR_W +: ADDR_W];
         end
      end
      w_a_free  = w_a_depth - w_a_used;
      w_a_ok    = i_alloc_req && w_a_qok && w_a_en && (i_alloc_len != '0) &&
                  (UW'(i_alloc_len) <= w_a_free);
      w_a_sum   = UW'(w_a_wptr) + UW'(i_alloc_len);
      w_a_wnext = (w_a_sum >= w_a_depth) ? PTR_W'(w_a_sum - w_a_depth) : PTR_W'(w_a_sum);
      w_a_addr  = w_a_init + ADDR_W'(w_a_wptr);
   end

   always_comb begin
      w_r_qok   = 1'b0;
      w_r_depth = '0;
      w_r_used  = '0;
      w_r_rptr  = '0;
      for (int q = 0; q < NUM_Q; q++) begin
         if (i_rptr_qid == QID_W'(q)) begin
            w_r_qok   = 1'b1;
            w_r_depth = UW'(i_q_depth[q*PTR_W +: PTR_W]);
            w_r_used  = r_used[q];
            w_r_rptr  = r_rptr[q];
         end
      end
      w_r_diff = UW'(i_rptr_data) + w_r_depth - UW'(w_r_rptr);
      w_r_cons = (w_r_diff >= w_r_depth) ? (w_r_diff - w_r_depth) : w_r_diff;
      w_r_ok   = i_rptr_we && w_r_qok && (UW'(i_rptr_data) < w_r_depth) &&
                 (w_r_cons <= w_r_used);
   end

   always_comb begin
      w_thr   = (i_coal_cnt == '0) ? CNT_W'(1) : i_coal_cnt;
      w_fall  = '0;
      w_hit_a = '0;
      w_hit_r = '0;
      w_set   = '0;
      for (int q = 0; q < NUM_Q; q++) begin
         w_fall[q]  = r_en_d[q] & ~i_q_enable[q];
         w_hit_a[q] = w_a_ok && (i_alloc_qid == QID_W'(q));
         w_hit_r[q] = w_r_ok && (i_rptr_qid == QID_W'(q));
         w_set[q]   = (r_pend[q] != '0) &&
                      ((r_pend[q] >= w_thr) ||
                       ((i_coal_tmo != '0) && (r_tmr[q] == i_coal_tmo)));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int q = 0; q < NUM_Q; q++) begin
            r_wptr[q] <= '0;
            r_rptr[q] <= '0;
            r_used[q] <= '0;
            r_pend[q] <= '0;
            r_tmr[q]  <= '0;
         end
         r_status <= '0;
         r_en_d   <= '0;
      end else begin
         r_en_d <= i_q_enable;
         for (int q = 0; q < NUM_Q; q++) begin
            if (w_fall[q]) begin
               r_wptr[q]   <= '0;
               r_rptr[q]   <= '0;
               r_used[q]   <= '0;
               r_pend[q]   <= '0;
               r_tmr[q]    <= '0;
               r_status[q] <= 1'b0;
            end else begin
               if (w_hit_a[q]) r_wptr[q] <= w_a_wnext;
               if (w_hit_r[q]) r_rptr[q] <= i_rptr_data;
               r_used[q] <= r_used[q] + (w_hit_a[q] ? UW'(i_alloc_len) : '0)
                                      - (w_hit_r[q] ? w_r_cons : '0);
               // A firing queue restarts coalescing; a same-cycle accept becomes the first pending message.
               if (w_set[q]) begin
                  r_pend[q]   <= w_hit_a[q] ? CNT_W'(1) : '0;
                  r_tmr[q]    <= '0;
                  r_status[q] <= 1'b1;
               end else begin
                  if (w_hit_a[q]) r_pend[q] <= r_pend[q] + CNT_W'(1);
                  if (r_pend[q] != '0) r_tmr[q] <= r_tmr[q] + TMR_W'(1);
                  else                 r_tmr[q] <= '0;
                  if (i_intr_clear[q]) r_status[q] <= 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         r_addr <= '0;
         r_drop <= '0;
         r_irq  <= 1'b0;
      end else begin
         r_done <= i_alloc_req;
         r_err  <= i_alloc_req && !w_a_ok;
         r_addr <= i_alloc_req ? w_a_addr : '0;
         if (i_alloc_req && !w_a_ok && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
         r_irq  <= |(r_status & i_intr_mask);
      end
   end

   always_comb begin
      o_q_wptr  = '0;
      o_q_used  = '0;
      o_q_empty = '0;
      for (int q = 0; q < NUM_Q; q++) begin
         o_q_wptr[q*PTR_W +: PTR_W] = r_wptr[q];
         o_q_used[q*UW +: UW]       = r_used[q];
         o_q_empty[q]               = (r_used[q] == '0);
      end
   end

   assign o_alloc_done    = r_done;
   assign o_alloc_err     = r_err;
   assign o_alloc_addr    = r_addr;
   assign o_intr_status   = r_status;
   assign o_msg_interrupt = r_irq;
   assign o_drop_cnt      = r_drop;

endmodule

// File: tb/tb_pcie_msg_queue_mgr.sv
// Directed bench for pcie_msg_queue_mgr: allocation responses go through an
// expected queue checked by a monitor; occupancy/interrupt state is checked inline.
module tb_pcie_msg_queue_mgr;
   localparam int NUM_Q = 15, QID_W = 4, ADDR_W = 10, PTR_W = 8, CNT_W = 4, TMR_W = 16;
   localparam int UW = PTR_W + 1;

   logic                       clk = 1'b0;
   logic                       rst_n;
   logic [NUM_Q-1:0]           i_q_enable;
   logic [NUM_Q*ADDR_W-1:0]    i_q_init_addr;
   logic [NUM_Q*PTR_W-1:0]     i_q_depth;
   logic                       i_alloc_req;
   logic [QID_W-1:0]           i_alloc_qid;
   logic [PTR_W-1:0]           i_alloc_len;
   logic                       o_alloc_done, o_alloc_err;
   logic [ADDR_W-1:0]          o_alloc_addr;
   logic                       i_rptr_we;
   logic [QID_W-1:0]           i_rptr_qid;
   logic [PTR_W-1:0]           i_rptr_data;
   logic [NUM_Q*PTR_W-1:0]     o_q_wptr;
   logic [NUM_Q*UW-1:0]        o_q_used;
   logic [NUM_Q-1:0]           o_q_empty;
   logic [CNT_W-1:0]           i_coal_cnt;
   logic [TMR_W-1:0]           i_coal_tmo;
   logic [NUM_Q-1:0]           i_intr_mask, i_intr_clear, o_intr_status;
   logic                       o_msg_interrupt;
   logic [15:0]                o_drop_cnt;

   int checks = 0;
   int errors = 0;
   // Entry layout: {check_addr, err, addr}
   logic [ADDR_W+1:0] exp_q[$];
   logic [ADDR_W+1:0] mon_e;

   pcie_msg_queue_mgr #(.NUM_Q(NUM_Q), .QID_W(QID_W), .ADDR_W(ADDR_W), .PTR_W(PTR_W),
                        .CNT_W(CNT_W), .TMR_W(TMR_W)) dut (
      .clk(clk), .rst_n(rst_n), .i_q_enable(i_q_enable), .i_q_init_addr(i_q_init_addr),
      .i_q_depth(i_q_depth), .i_alloc_req(i_alloc_req), .i_alloc_qid(i_alloc_qid),
      .i_alloc_len(i_alloc_len), .o_alloc_done(o_alloc_done), .o_alloc_err(o_alloc_err),
      .o_alloc_addr(o_alloc_addr), .i_rptr_we(i_rptr_we), .i_rptr_qid(i_rptr_qid),
      .i_rptr_data(i_rptr_data), .o_q_wptr(o_q_wptr), .o_q_used(o_q_used),
      .o_q_empty(o_q_empty), .i_coal_cnt(i_coal_cnt), .i_coal_tmo(i_coal_tmo),
      .i_intr_mask(i_intr_mask), .i_intr_clear(i_intr_clear), .o_intr_status(o_intr_status),
      .o_msg_interrupt(o_msg_interrupt), .o_drop_cnt(o_drop_cnt));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] wptr_of(input int q);
      return 32'(o_q_wptr[q*PTR_W +: PTR_W]);
   endfunction

   function automatic logic [31:0] used_of(input int q);
      return 32'(o_q_used[q*UW +: UW]);
   endfunction

   always @(posedge clk) begin
      #1;
      if (rst_n && o_alloc_done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done with no expected entry (err=%0b addr=0x%0h)",
                     o_alloc_err, o_alloc_addr);
         end else begin
            mon_e = exp_q.pop_front();
            chk("alloc_err", 32'(o_alloc_err), 32'(mon_e[ADDR_W]));
            if (mon_e[ADDR_W+1]) chk("alloc_addr", 32'(o_alloc_addr), 32'(mon_e[ADDR_W-1:0]));
         end
      end
   end

   task automatic push_exp(input logic exp_err, input logic [ADDR_W-1:0] exp_addr);
      exp_q.push_back({~exp_err, exp_err, exp_addr});
   endtask

   task automatic alloc(input int qid, input int len, input logic exp_err,
                        input logic [ADDR_W-1:0] exp_addr);
      @(negedge clk);
      i_alloc_req = 1'b1;
      i_alloc_qid = QID_W'(qid);
      i_alloc_len = PTR_W'(len);
      push_exp(exp_err, exp_addr);
      @(negedge clk);
      i_alloc_req = 1'b0;
   endtask

   task automatic rptr(input int qid, input int data);
      @(negedge clk);
      i_rptr_we   = 1'b1;
      i_rptr_qid  = QID_W'(qid);
      i_rptr_data = PTR_W'(data);
      @(negedge clk);
      i_rptr_we = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 10) begin
         @(posedge clk);
         n++;
      end
      #2;
      chk("drain_expected_queue", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      i_q_enable = '1;
      i_alloc_req = 1'b0; i_alloc_qid = '0; i_alloc_len = '0;
      i_rptr_we = 1'b0; i_rptr_qid = '0; i_rptr_data = '0;
      i_coal_cnt = 4'd15; i_coal_tmo = '0;
      i_intr_mask = '0; i_intr_clear = '0;
      for (int q = 0; q < NUM_Q; q++) begin
         i_q_init_addr[q*ADDR_W +: ADDR_W] = ADDR_W'(q * 32);
         i_q_depth[q*PTR_W +: PTR_W]       = PTR_W'(16);
      end
      i_q_init_addr[0*ADDR_W +: ADDR_W] = 10'h000;
      i_q_init_addr[1*ADDR_W +: ADDR_W] = 10'h040;  i_q_depth[1*PTR_W +: PTR_W] = 8'd8;
      i_q_init_addr[2*ADDR_W +: ADDR_W] = 10'h100;  i_q_depth[2*PTR_W +: PTR_W] = 8'd8;
      i_q_init_addr[3*ADDR_W +: ADDR_W] = 10'h300;  i_q_depth[3*PTR_W +: PTR_W] = 8'd8;
      i_q_init_addr[5*ADDR_W +: ADDR_W] = 10'h200;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_done", 32'(o_alloc_done), 0);
      chk("reset_drop", 32'(o_drop_cnt), 0);
      chk("reset_status", 32'(o_intr_status), 0);
      chk("reset_used_any", 32'(|o_q_used), 0);
      chk("reset_empty", 32'(o_q_empty), 32'(15'h7FFF));
      @(negedge clk);
      rst_n = 1'b1;

      // Basic allocation and overflow on q2 (depth 8, base 0x100)
      alloc(2, 3, 1'b0, 10'h100);
      alloc(2, 3, 1'b0, 10'h103);
      chk("q2_wptr_6", wptr_of(2), 6);
      chk("q2_used_6", used_of(2), 6);
      alloc(2, 3, 1'b1, 10'h000);
      chk("drop_after_full", 32'(o_drop_cnt), 1);
      chk("q2_used_unchanged", used_of(2), 6);

      // Wrap-around
      rptr(2, 6);
      chk("q2_used_0", used_of(2), 0);
      chk("q2_empty", 32'(o_q_empty[2]), 1);
      alloc(2, 4, 1'b0, 10'h106);
      chk("q2_wptr_wrap", wptr_of(2), 2);
      chk("q2_used_4", used_of(2), 4);
      rptr(2, 7);
      chk("q2_used_3", used_of(2), 3);

      // Count coalescing on q5
      i_coal_cnt = 4'd3; i_coal_tmo = '0; i_intr_mask = 15'(1 << 5);
      alloc(5, 1, 1'b0, 10'h200);
      alloc(5, 1, 1'b0, 10'h201);
      chk("q5_status_after_2", 32'(o_intr_status[5]), 0);
      alloc(5, 1, 1'b0, 10'h202);
      chk("q5_status_same_cycle", 32'(o_intr_status[5]), 0);
      @(posedge clk); #1;
      chk("q5_status_rise", 32'(o_intr_status[5]), 1);
      chk("irq_lag", 32'(o_msg_interrupt), 0);
      @(posedge clk); #1;
      chk("irq_rise", 32'(o_msg_interrupt), 1);
      @(negedge clk);
      i_intr_clear = 15'(1 << 5);
      @(negedge clk);
      i_intr_clear = '0;
      chk("q5_cleared", 32'(o_intr_status[5]), 0);
      i_intr_mask = '0;

      // Timeout coalescing on q0
      i_coal_cnt = 4'd15; i_coal_tmo = 16'd20;
      alloc(0, 1, 1'b0, 10'h000);
      repeat (20) @(posedge clk);
      #1;
      chk("q0_tmo_not_yet", 32'(o_intr_status[0]), 0);
      @(posedge clk); #1;
      chk("q0_tmo_fire", 32'(o_intr_status[0]), 1);
      @(negedge clk);
      i_intr_clear = 15'(1);
      @(negedge clk);
      i_intr_clear = '0;
      chk("q0_w1c", 32'(o_intr_status[0]), 0);

      // Clear coincident with a new set: set wins
      i_coal_cnt = 4'd1;
      @(negedge clk);
      i_alloc_req = 1'b1; i_alloc_qid = 4'd0; i_alloc_len = 8'd1;
      push_exp(1'b0, 10'h001);
      @(negedge clk);
      i_alloc_req = 1'b0;
      i_intr_clear = 15'(1);
      chk("q0_pre_set", 32'(o_intr_status[0]), 0);
      @(negedge clk);
      i_intr_clear = '0;
      chk("set_wins_over_clear", 32'(o_intr_status[0]), 1);

      // Same-cycle alloc and read-pointer write on q1
      alloc(1, 5, 1'b0, 10'h040);
      chk("q1_used_5", used_of(1), 5);
      @(negedge clk);
      i_alloc_req = 1'b1; i_alloc_qid = 4'd1; i_alloc_len = 8'd2;
      i_rptr_we = 1'b1; i_rptr_qid = 4'd1; i_rptr_data = 8'd5;
      push_exp(1'b0, 10'h045);
      @(negedge clk);
      i_alloc_req = 1'b0; i_rptr_we = 1'b0;
      chk("q1_used_simul", used_of(1), 2);
      chk("q1_wptr_simul", wptr_of(1), 7);

      // Rejects and ignored writes
      alloc(15, 1, 1'b1, 10'h000);
      chk("drop_bad_qid", 32'(o_drop_cnt), 2);
      alloc(1, 0, 1'b1, 10'h000);
      chk("drop_len0", 32'(o_drop_cnt), 3);
      rptr(1, 9);
      chk("rptr_oob_ignored", used_of(1), 2);
      rptr(1, 2);
      chk("rptr_overconsume_ignored", used_of(1), 2);

      // Disable q3 with used=4 and status set
      alloc(3, 4, 1'b0, 10'h300);
      @(negedge clk);
      chk("q3_used_4", used_of(3), 4);
      chk("q3_status", 32'(o_intr_status[3]), 1);
      i_q_enable[3] = 1'b0;
      i_alloc_req = 1'b1; i_alloc_qid = 4'd3; i_alloc_len = 8'd1;
      push_exp(1'b1, 10'h000);
      @(negedge clk);
      i_alloc_req = 1'b0;
      chk("q3_wptr_cleared", wptr_of(3), 0);
      chk("q3_used_cleared", used_of(3), 0);
      chk("q3_status_cleared", 32'(o_intr_status[3]), 0);
      chk("q3_empty", 32'(o_q_empty[3]), 1);
      chk("drop_disabled", 32'(o_drop_cnt), 4);
      drain();

      // Asynchronous reset while a response is on the outputs
      @(negedge clk);
      i_alloc_req = 1'b1; i_alloc_qid = 4'd1; i_alloc_len = 8'd1;
      push_exp(1'b0, 10'h047);
      @(posedge clk);
      #2;
      i_alloc_req = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("async_rst_done", 32'(o_alloc_done), 0);
      chk("async_rst_drop", 32'(o_drop_cnt), 0);
      chk("async_rst_status", 32'(o_intr_status), 0);
      chk("async_rst_irq", 32'(o_msg_interrupt), 0);
      chk("async_rst_used", 32'(|o_q_used), 0);
      chk("async_rst_wptr", 32'(|o_q_wptr), 0);
      repeat (2) @(negedge clk);
      i_q_enable = '1;
      rst_n = 1'b1;
      alloc(2, 1, 1'b0, 10'h100);
      chk("post_reset_q2_used", used_of(2), 1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pcie_msg_queue_mgr.md
Name: pcie_msg_queue_mgr

Overview:
- Parametrised successor to the fixed 15-queue message handler queue logic: NUM_Q circular SRAM queues, each with its own init address and depth.
- Allocates SRAM space for each assembled message and tracks write pointer, firmware read pointer and occupancy per queue.
- Generates per-queue interrupt status with count/timeout coalescing and W1C clear.
- Sits between pcie_msg_receiver (allocation requester) and the SFR block (config, read pointers, interrupt registers).

Parameters:
NUM_Q, 15, number of queues (1..32)
QID_W, 4, queue-id width, must satisfy 2^QID_W >= NUM_Q
ADDR_W, 10, SRAM entry-address width
PTR_W, 8, per-queue pointer/depth/length width in 256-bit entries
CNT_W, 4, coalescing message-count width
TMR_W, 16, coalescing timeout width in clk cycles

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
i_q_enable  in  NUM_Q  per-queue enable
i_q_init_addr  in  NUM_Q*ADDR_W  queue q base address at slice [q*ADDR_W +: ADDR_W]
i_q_depth  in  NUM_Q*PTR_W  queue q depth in entries, 1..2^PTR_W-1
i_alloc_req  in  1  allocation request pulse
i_alloc_qid  in  QID_W  target queue
i_alloc_len  in  PTR_W  message length in entries, >=1
o_alloc_done  out  1  allocation result pulse
o_alloc_err  out  1  with o_alloc_done: request rejected
o_alloc_addr  out  ADDR_W  with o_alloc_done: start address (init_addr + wptr)
i_rptr_we  in  1  firmware read-pointer write strobe
i_rptr_qid  in  QID_W  queue for read-pointer write
i_rptr_data  in  PTR_W  new read pointer
o_q_wptr  out  NUM_Q*PTR_W  per-queue write pointers
o_q_used  out  NUM_Q*(PTR_W+1)  per-queue occupancy
o_q_empty  out  NUM_Q  used == 0
i_coal_cnt  in  CNT_W  message-count threshold; 0 is treated as 1
i_coal_tmo  in  TMR_W  timeout; 0 disables the timer
i_intr_mask  in  NUM_Q  1 = interrupt enabled
i_intr_clear  in  NUM_Q  W1C pulse per queue
o_intr_status  out  NUM_Q  sticky per-queue status
o_msg_interrupt  out  1  registered OR of (o_intr_status & i_intr_mask)
o_drop_cnt  out  16  count of rejected allocations, saturating

Behaviour:
- Reset: all outputs, wptr, rptr, used, coalescing counters, timers and status are cleared to 0.
- Allocation timing:
  - i_alloc_req sampled at cycle N; o_alloc_done is a one-cycle pulse at N+1 with err and addr valid.
  - A new request is accepted every cycle; the request at N+1 sees state already updated by the request at N.
- Reject (err=1, no pointer change, o_drop_cnt+1 saturating at 0xFFFF) when any of the following holds:
  - qid >= NUM_Q;
  - queue disabled;
  - len == 0;
  - len > depth - used.
- Accept updates:
  - addr = init_addr + wptr, truncated to ADDR_W;
  - wptr = (wptr + len) mod depth;
  - used += len;
  - pending_cnt[q] += 1.
- The receiver wraps its own per-beat addresses modulo depth.
- Read-pointer write: consumed = (rptr_data - rptr + depth) mod depth.
  - If consumed <= used: rptr = rptr_data and used -= consumed.
  - Otherwise the write is ignored.
  - Writes with rptr_data >= depth or an invalid qid are ignored.
- Same-queue alloc and rptr write in the same cycle: both apply, used_next = used + len - consumed. The full check uses pre-update used.
- Coalescing, per queue:
  - The timer starts at 0 on the accept that makes pending_cnt go from 0 to 1.
  - The timer increments every cycle while pending_cnt != 0.
  - Status bit q is set when pending_cnt >= max(i_coal_cnt,1), or when the timer == i_coal_tmo with tmo != 0.
  - On set, pending_cnt and timer clear.
  - The set condition is evaluated on registered state, so status rises 1 cycle after the triggering accept.
- Clear: i_intr_clear[q] clears status q. If set and clear occur in the same cycle, set wins.
- o_msg_interrupt lags o_intr_status by 1 cycle.
- Enable falling edge on q (registered detect): the next cycle clears wptr, rptr, used, pending_cnt, timer and status for q. An in-flight alloc to q in that same cycle is rejected.
- Mid-operation reset: all state clears immediately, asynchronously. No o_alloc_done is produced for a request sampled in the same cycle as reset.

Test Plan:
- Depth=8, init=0x100, allocs len 3,3 on q2 -> addr 0x100 then 0x103, wptr=6, used=6. Third alloc len 3 -> err=1, drop_cnt=1.
- Wrap: q2 rptr write 6 (used->0), alloc len 4 -> addr 0x106, wptr=2, used=4. Rptr write 7 when used=4 (consumed 1) -> rptr=7, used=3.
- Coalescing: coal_cnt=3, tmo=0, three accepts on q5 -> status[5] rises 1 cycle after the 3rd, and o_msg_interrupt 1 cycle later if mask[5]=1.
- Timeout: coal_cnt=15, tmo=20, one accept on q0 -> status[0] set 21 cycles after done; clear pulse -> 0. Clear coincident with a new set -> stays 1.
- Simultaneous events: same-cycle alloc len 2 and rptr write consuming 5 on q1 with used=5 -> used=2. Invalid qid=15 with NUM_Q=15 -> err, drop_cnt increments.
- Disable q3 with used=4 -> next cycle wptr=rptr=used=0 and status[3]=0. Reset asserted mid-burst -> all outputs are 0 asynchronously.
